// File: rtl/rooth_timer_if.sv
// ----------------------------------------------------------------------------
// rooth_timer_if
//   Peripheral bus bundle for the rooth_timer register block.
//   One strobe per access. A read returns its data on the cycle after the
//   strobe. The interrupt vector travels with the bus so that one bundle
//   carries everything a core needs from the timer.
//
//   Signals
//     req      : access strobe, one cycle per access
//     we       : 1 = write, 0 = read (qualified by req)
//     addr     : byte address, bits [1:0] ignored
//     wdata    : write data
//     rdata    : read data, valid the cycle after a read strobe
//     int_flag : interrupt vector to the core-local interrupt controller
//
//   Modports
//     master : the bus initiator (CPU side)
//     slave  : the timer
// ----------------------------------------------------------------------------
interface rooth_timer_if #(
    parameter int ADDR_W    = 4,
    parameter int CPU_WIDTH = 32,
    parameter int INT_W     = 8
);
    logic                 req;
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [CPU_WIDTH-1:0] wdata;
    logic [CPU_WIDTH-1:0] rdata;
    logic [INT_W-1:0]     int_flag;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  int_flag
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output int_flag
    );
endinterface

// File: rtl/rooth_timer.sv
// ----------------------------------------------------------------------------
// rooth_timer
//   Memory-mapped machine timer with a prescaler, a compare match, an
//   auto-reload or one-shot mode, and a level interrupt that is cleared by
//   writing 1 to CTRL.PEND.
//
//   Register map (word registers)
//     0x0 CTRL  : [0] EN, [1] IE, [2] PEND (write 1 to clear), [3] AR
//     0x4 COUNT : current count
//     0x8 CMP   : compare value, 0 disables matching
//     0xC PSC   : prescaler divide-1, the count advances every PSC+1 clocks
//
//   Ports
//     clk : system clock
//     rst : synchronous reset, active-high
//     bus : rooth_timer_if.slave (req, we, addr, wdata, rdata, int_flag)
//
//   Parameters
//     ADDR_W    : bus byte-address width
//     INT_BIT   : bit of int_flag that this timer drives (0..INT_W-1)
//     CPU_WIDTH : data width
//     INT_W     : interrupt vector width
// ----------------------------------------------------------------------------
module rooth_timer #(
    parameter int ADDR_W    = 4,
    parameter int INT_BIT   = 0,
    parameter int CPU_WIDTH = 32,
    parameter int INT_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    rooth_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_COUNT = 2'd1,
        REG_CMP   = 2'd2,
        REG_PSC   = 2'd3
    } reg_sel_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                 en;
    logic                 ie;
    logic                 pend;
    logic                 ar;
    logic [CPU_WIDTH-1:0] count;
    logic [CPU_WIDTH-1:0] cmp;
    logic [CPU_WIDTH-1:0] psc;
    logic [CPU_WIDTH-1:0] psc_cnt;
    logic [CPU_WIDTH-1:0] rdata;
    logic [INT_W-1:0]     int_flag;

    logic                 en_nxt;
    logic                 ie_nxt;
    logic                 pend_nxt;
    logic                 ar_nxt;
    logic [CPU_WIDTH-1:0] count_nxt;
    logic [CPU_WIDTH-1:0] cmp_nxt;
    logic [CPU_WIDTH-1:0] psc_nxt;
    logic [CPU_WIDTH-1:0] psc_cnt_nxt;
    logic [CPU_WIDTH-1:0] rdata_nxt;
    logic [INT_W-1:0]     int_flag_nxt;

    assign bus.rdata    = rdata;
    assign bus.int_flag = int_flag;

    // ------------------------------------------------------------------------
    // Address decode. Any word index above 3 is unmapped. Those addresses
    // read as 0 and drop writes.
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] word_addr;
    logic              mapped;
    reg_sel_e          sel;

    assign word_addr = bus.addr >> 2;
    assign mapped    = (word_addr < ADDR_W'(4));
    assign sel       = reg_sel_e'(word_addr[1:0]);

    logic wr;
    logic rd;
    logic ctrl_wr;
    logic count_wr;
    logic cmp_wr;
    logic psc_wr;

    assign wr       = bus.req & bus.we & mapped;
    assign rd       = bus.req & ~bus.we;
    assign ctrl_wr  = wr && (sel == REG_CTRL);
    assign count_wr = wr && (sel == REG_COUNT);
    assign cmp_wr   = wr && (sel == REG_CMP);
    assign psc_wr   = wr && (sel == REG_PSC);

    // ------------------------------------------------------------------------
    // Tick and match.
    // A software COUNT write pre-empts the tick in the same cycle, so no
    // match is evaluated then. CMP == 0 disables matching entirely.
    // ------------------------------------------------------------------------
    logic                 tick;
    logic                 match;
    logic [CPU_WIDTH-1:0] count_inc;

    assign tick      = en && (psc_cnt == psc);
    assign count_inc = count + CPU_WIDTH'(1);
    assign match     = tick && !count_wr && (cmp != '0) && (count_inc == cmp);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is defaulted first so that no
        // path leaves a variable unassigned, which would infer a latch.
        en_nxt       = en;
        ie_nxt       = ie;
        pend_nxt     = pend;
        ar_nxt       = ar;
        count_nxt    = count;
        cmp_nxt      = cmp;
        psc_nxt      = psc;
        psc_cnt_nxt  = psc_cnt;
        rdata_nxt    = rdata;
        int_flag_nxt = '0;

        // Prescaler: restart on COUNT/PSC writes so a fresh period begins.
        if (count_wr || psc_wr) begin
            psc_cnt_nxt = '0;
        end else if (en) begin
            psc_cnt_nxt = tick ? '0 : psc_cnt + CPU_WIDTH'(1);
        end

        // Counter
        if (count_wr) begin
            count_nxt = bus.wdata;
        end else if (match) begin
            count_nxt = ar ? '0 : cmp;
        end else if (tick) begin
            count_nxt = count_inc;
        end

        if (cmp_wr) cmp_nxt = bus.wdata;
        if (psc_wr) psc_nxt = bus.wdata;

        // Software CTRL write is applied first. A hardware match then
        // overrides it, so the set of PEND and the one-shot stop both win.
        if (ctrl_wr) begin
            en_nxt = bus.wdata[0];
            ie_nxt = bus.wdata[1];
            ar_nxt = bus.wdata[3];
            if (bus.wdata[2]) pend_nxt = 1'b0;
        end
        if (match) begin
            pend_nxt = 1'b1;
            if (!ar) en_nxt = 1'b0;
        end

        // Read data captures the pre-edge register contents.
        if (rd) begin
            if (!mapped) begin
                rdata_nxt = '0;
            end else begin
                case (sel)
                    REG_CTRL:  rdata_nxt = CPU_WIDTH'({ar, pend, ie, en});
                    REG_COUNT: rdata_nxt = count;
                    REG_CMP:   rdata_nxt = cmp;
                    REG_PSC:   rdata_nxt = psc;
                    default:   rdata_nxt = '0;
                endcase
            end
        end

        // Interrupt follows the registered PEND/IE, one cycle behind.
        int_flag_nxt[INT_BIT] = pend & ie;
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the same pre-edge values regardless of statement order.
        if (rst) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            pend     <= 1'b0;
            ar       <= 1'b0;
            count    <= '0;
            cmp      <= '0;
            psc      <= '0;
            psc_cnt  <= '0;
            rdata    <= '0;
            int_flag <= '0;
        end else begin
            en       <= en_nxt;
            ie       <= ie_nxt;
            pend     <= pend_nxt;
            ar       <= ar_nxt;
            count    <= count_nxt;
            cmp      <= cmp_nxt;
            psc      <= psc_nxt;
            psc_cnt  <= psc_cnt_nxt;
            rdata    <= rdata_nxt;
            int_flag <= int_flag_nxt;
        end
    end

endmodule

// File: tb/tb_rooth_timer.sv
// ----------------------------------------------------------------------------
// tb_rooth_timer
//   Directed bench for rooth_timer. The bus is 5 bits wide here so that
//   address 0x10 is a real, unmapped location. Inputs change on the falling
//   edge, and outputs are sampled on the falling edge after the rising edge
//   that produced them. Every task is entered at a falling edge and returns
//   at one.
// ----------------------------------------------------------------------------
module tb_rooth_timer;

    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rooth_timer_if #(.ADDR_W(ADDR_W)) bus ();

    rooth_timer #(
        .ADDR_W  (ADDR_W),
        .INT_BIT (0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.req   = 1'b0;
        bus.we    = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = a;
        @(negedge clk);
        bus.req  = 1'b0;
        d        = bus.rdata;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] rd;

    // Auto-reload COUNT readback sequence, and the matching int_flag values.
    logic [31:0] ar_cnt [6] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    logic [7:0]  ar_int [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

    initial begin
        rst       = 1'b1;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        @(negedge clk);
        do_reset();

        // ---------------- Reset mid-count with PEND set ----------------
        bus_write(5'h08, 32'd3);
        bus_write(5'h00, 32'hB);
        repeat (4) @(negedge clk);
        bus_read(5'h08, rd);
        check("pre_reset_cmp", rd, 32'd3);
        check("pre_reset_int", {24'd0, bus.int_flag}, 32'h1);
        do_reset();
        check("rst_int", {24'd0, bus.int_flag}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        bus_read(5'h00, rd); check("rst_ctrl", rd, 32'h0);
        bus_read(5'h04, rd); check("rst_count", rd, 32'h0);
        bus_read(5'h08, rd); check("rst_cmp", rd, 32'h0);
        bus_read(5'h0C, rd); check("rst_psc", rd, 32'h0);

        // ---------------- Auto-reload: CMP=5, PSC=0, CTRL=0xB ----------------
        bus_write(5'h08, 32'd5);
        bus_write(5'h0C, 32'd0);
        bus_write(5'h00, 32'hB);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 5'h04;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("ar_count_%0d", i), bus.rdata, ar_cnt[i]);
            check($sformatf("ar_int_%0d", i), {24'd0, bus.int_flag}, {24'd0, ar_int[i]});
        end
        bus.req = 1'b0;
        bus_read(5'h00, rd);
        check("ar_ctrl", rd, 32'hF);
        do_reset();

        // ---------------- One-shot with prescaler: PSC=3, CMP=2, CTRL=0x3 ----------------
        bus_write(5'h0C, 32'd3);
        bus_write(5'h08, 32'd2);
        bus_write(5'h00, 32'h3);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 5'h00;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("os_ctrl_%0d", k), bus.rdata, (k == 9) ? 32'h6 : 32'h3);
            check($sformatf("os_int_%0d", k), {24'd0, bus.int_flag}, (k == 9) ? 32'h1 : 32'h0);
        end
        bus.req = 1'b0;
        bus_read(5'h04, rd); check("os_count", rd, 32'd2);
        repeat (5) @(negedge clk);
        bus_read(5'h04, rd); check("os_count_hold", rd, 32'd2);
        bus_read(5'h00, rd); check("os_ctrl_stopped", rd, 32'h6);
        do_reset();

        // ---------------- Clear race on the match cycle ----------------
        bus_write(5'h08, 32'd5);
        bus_write(5'h00, 32'hB);
        repeat (4) @(negedge clk);
        bus_write(5'h00, 32'hF);              // lands on the match edge
        check("race_int_before", {24'd0, bus.int_flag}, 32'h0);
        @(negedge clk);
        check("race_int_set", {24'd0, bus.int_flag}, 32'h1);
        @(negedge clk);
        check("race_int_hold", {24'd0, bus.int_flag}, 32'h1);
        bus_write(5'h00, 32'hF);              // plain clear, no match this edge
        check("clr_int_lag", {24'd0, bus.int_flag}, 32'h1);
        @(negedge clk);
        check("clr_int_drop", {24'd0, bus.int_flag}, 32'h0);
        do_reset();

        // ---------------- IE masking ----------------
        bus_write(5'h08, 32'd2);
        bus_write(5'h00, 32'h9);
        repeat (4) @(negedge clk);
        check("mask_int", {24'd0, bus.int_flag}, 32'h0);
        bus_read(5'h00, rd);
        check("mask_ctrl", rd, 32'hD);
        bus_write(5'h00, 32'hB);
        check("ie_int_lag", {24'd0, bus.int_flag}, 32'h0);
        @(negedge clk);
        check("ie_int_set", {24'd0, bus.int_flag}, 32'h1);
        do_reset();

        // ---------------- CMP=0 free-run wrap, unmapped read ----------------
        bus_write(5'h04, 32'hFFFF_FFFE);
        bus_write(5'h00, 32'h1);
        repeat (2) @(negedge clk);
        bus_read(5'h04, rd); check("wrap_count", rd, 32'h0);
        bus_read(5'h00, rd); check("wrap_ctrl", rd, 32'h1);
        check("wrap_int", {24'd0, bus.int_flag}, 32'h0);
        @(negedge clk);
        check("rdata_hold", bus.rdata, 32'h1);
        bus_read(5'h10, rd); check("unmapped_read", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
